// File: rtl/intpol2_d4_sched.sv
// Two-channel round-robin scheduler sharing one intpol2_D4 core, with a
// programmable watchdog that aborts a hung job and drains the core afterwards.
module intpol2_d4_sched #(
    parameter int MEM_SIZE_Y = 7,
    parameter int TO_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [MEM_SIZE_Y:0]   ilen0,
    input  logic [MEM_SIZE_Y:0]   ilen1,
    input  logic                  mode0,
    input  logic                  mode1,
    input  logic                  bypass0,
    input  logic                  bypass1,
    input  logic                  empty0,
    input  logic                  empty1,
    input  logic                  afull0,
    input  logic                  afull1,
    input  logic                  core_busy,
    input  logic                  core_done,
    input  logic                  core_rd_en,
    input  logic                  core_wr_en,
    input  logic [TO_W-1:0]       timeout_lim,
    output logic                  core_start,
    output logic [MEM_SIZE_Y:0]   core_ilen,
    output logic                  core_mode,
    output logic                  core_bypass,
    output logic                  core_empty,
    output logic                  core_afull,
    output logic                  rd_en0,
    output logic                  rd_en1,
    output logic                  wr_en0,
    output logic                  wr_en1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RUN, S_DONE, S_ABORT, S_DRAIN
    } state_t;

    state_t              state_q;
    logic                last_gnt_q;
    logic [TO_W-1:0]     wd_q, wd_d;
    logic                gnt0_q, gnt1_q, start_q;
    logic                done0_q, done1_q, err0_q, err1_q;
    logic [MEM_SIZE_Y:0] ilen_q;
    logic                mode_q, bypass_q;
    logic                pick1, timeout_hit, en_ok;

    always_comb begin
        wd_d        = (&wd_q) ? wd_q : wd_q + TO_W'(1);
        timeout_hit = (timeout_lim != '0) && (wd_q == timeout_lim - TO_W'(1));
        // On contention the channel that did not win last time is served.
        pick1       = req1 && (!req0 || !last_gnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            wd_q       <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            start_q    <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            ilen_q     <= '0;
            mode_q     <= 1'b0;
            bypass_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        gnt0_q     <= !pick1;
                        gnt1_q     <= pick1;
                        last_gnt_q <= pick1;
                        ilen_q     <= pick1 ? ilen1 : ilen0;
                        mode_q     <= pick1 ? mode1 : mode0;
                        bypass_q   <= pick1 ? bypass1 : bypass0;
                        start_q    <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    wd_q    <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    wd_q <= wd_d;
                    if (core_done) begin
                        done0_q <= gnt0_q;
                        done1_q <= gnt1_q;
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        err0_q  <= gnt0_q;
                        err1_q  <= gnt1_q;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                        state_q <= S_ABORT;
                    end
                end
                S_DONE: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ABORT: state_q <= S_DRAIN;
                S_DRAIN: if (!core_busy) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Flags: granted channel while a job is live, stalled when idle/aborting,
    // and forced "data available / room free" while draining a hung core.
    always_comb begin
        core_empty = 1'b1;
        core_afull = 1'b1;
        case (state_q)
            S_START, S_RUN, S_DONE: begin
                core_empty = gnt1_q ? empty1 : empty0;
                core_afull = gnt1_q ? afull1 : afull0;
            end
            S_DRAIN: begin
                core_empty = 1'b0;
                core_afull = 1'b0;
            end
            default: ;
        endcase
    end

    assign en_ok       = (state_q != S_DRAIN);
    assign rd_en0      = core_rd_en & gnt0_q & en_ok;
    assign rd_en1      = core_rd_en & gnt1_q & en_ok;
    assign wr_en0      = core_wr_en & gnt0_q & en_ok;
    assign wr_en1      = core_wr_en & gnt1_q & en_ok;
    assign core_start  = start_q;
    assign core_ilen   = ilen_q;
    assign core_mode   = mode_q;
    assign core_bypass = bypass_q;
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;

endmodule

// File: tb/tb_intpol2_d4_sched.sv
// Directed bench for intpol2_d4_sched: single job, contention, watchdog abort,
// done/timeout collision, config stability and asynchronous reset mid-job.
module tb_intpol2_d4_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 0, req1 = 0;
    logic [7:0]  ilen0 = '0, ilen1 = '0;
    logic        mode0 = 0, mode1 = 0, bypass0 = 0, bypass1 = 0;
    logic        empty0 = 1, empty1 = 1, afull0 = 1, afull1 = 1;
    logic        core_busy = 0, core_done = 0, core_rd_en = 0, core_wr_en = 0;
    logic [15:0] timeout_lim = '0;
    logic        core_start, core_mode, core_bypass, core_empty, core_afull;
    logic [7:0]  core_ilen;
    logic        rd_en0, rd_en1, wr_en0, wr_en1, gnt0, gnt1, done0, done1, err0, err1;

    int n_checks = 0;
    int n_fail   = 0;
    int gcount, starts, leak;

    intpol2_d4_sched #(.MEM_SIZE_Y(7), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .ilen0(ilen0), .ilen1(ilen1),
        .mode0(mode0), .mode1(mode1), .bypass0(bypass0), .bypass1(bypass1),
        .empty0(empty0), .empty1(empty1), .afull0(afull0), .afull1(afull1),
        .core_busy(core_busy), .core_done(core_done), .core_rd_en(core_rd_en),
        .core_wr_en(core_wr_en), .timeout_lim(timeout_lim), .core_start(core_start),
        .core_ilen(core_ilen), .core_mode(core_mode), .core_bypass(core_bypass),
        .core_empty(core_empty), .core_afull(core_afull), .rd_en0(rd_en0), .rd_en1(rd_en1),
        .wr_en0(wr_en0), .wr_en1(wr_en1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0),
        .done1(done1), .err0(err0), .err1(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        @(negedge clk);
        tick();
        chk("rst_gnt",   {gnt0, gnt1}, 2'b00);
        chk("rst_start", core_start, 1'b0);
        chk("rst_ilen",  core_ilen, 8'd0);
        chk("rst_flags", {core_empty, core_afull}, 2'b11);
        chk("rst_pulse", {done0, done1, err0, err1}, 4'b0000);
        rst = 1'b0;
        tick();

        // Single job: core_done on the 21st cycle after start -> gnt for 23 cycles.
        req0 = 1; ilen0 = 8'd16; mode0 = 1; empty0 = 0; afull0 = 0;
        core_rd_en = 1; core_wr_en = 1;
        tick();
        chk("s_start", {gnt0, gnt1, core_start}, 3'b101);
        chk("s_ilen",  core_ilen, 8'd16);
        chk("s_mode",  core_mode, 1'b1);
        req0 = 0;
        gcount = 1; starts = 1; leak = 0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (gnt0) gcount++;
            if (core_start) starts++;
            if (rd_en1 || wr_en1) leak++;
        end
        chk("s_flags", {core_empty, core_afull}, 2'b00);
        chk("s_rden0", {rd_en0, wr_en0}, 2'b11);
        core_done = 1;
        tick();
        core_done = 0;
        if (gnt0) gcount++;
        chk("s_done0", {done0, done1}, 2'b10);
        tick();
        chk("s_gntcnt", gcount, 23);
        chk("s_starts", starts, 1);
        chk("s_leak",   leak, 0);
        chk("s_idle",   {gnt0, done0, core_empty}, 3'b001);
        core_rd_en = 0; core_wr_en = 0;

        // Contention from fresh reset: ch0, ch1, ch0, ch1.
        rst = 1; tick(); rst = 0; tick();
        req0 = 1; req1 = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("c_gnt", {gnt0, gnt1}, (j % 2 == 0) ? 2'b10 : 2'b01);
            core_done = 1;
            tick();
            tick();
            core_done = 0;
            chk("c_done", {done0, done1}, (j % 2 == 0) ? 2'b10 : 2'b01);
            if (j == 3) begin req0 = 0; req1 = 0; end
            tick();
            chk("c_idle", {gnt0, gnt1}, 2'b00);
        end

        // Watchdog abort at limit 8, core busy until 5 cycles into DRAIN.
        timeout_lim = 16'd8; req0 = 1;
        tick();
        req0 = 0; leak = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (err0 || !gnt0) leak++;
        end
        chk("t_run", leak, 0);
        tick();
        chk("t_err0",  {err0, gnt0}, 2'b10);
        chk("t_abort", {core_empty, core_afull}, 2'b11);
        core_busy = 1; core_rd_en = 1; core_wr_en = 1;
        tick();
        chk("t_drain", {err0, core_empty, core_afull}, 3'b000);
        leak = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            if (core_empty || wr_en0 || rd_en0 || wr_en1) leak++;
        end
        chk("t_drain_hold", leak, 0);
        core_busy = 0;
        tick();
        chk("t_idle", core_empty, 1'b1);
        core_rd_en = 0; core_wr_en = 0;

        // core_done on the count==lim-1 cycle beats the timeout.
        req0 = 1;
        tick();
        req0 = 0;
        for (int k = 1; k <= 8; k++) tick();
        core_done = 1;
        tick();
        core_done = 0;
        chk("d_done0", {done0, err0}, 2'b10);
        tick();
        chk("d_noerr", {err0, gnt0}, 2'b00);

        // Config latched only at grant.
        timeout_lim = '0; req0 = 1; ilen0 = 8'd16;
        tick();
        chk("cfg_grant", core_ilen, 8'd16);
        tick();
        ilen0 = 8'd3;
        tick();
        chk("cfg_run", core_ilen, 8'd16);
        core_done = 1;
        tick();
        core_done = 0;
        chk("cfg_done", core_ilen, 8'd16);
        tick();
        chk("cfg_idle", core_ilen, 8'd16);
        tick();
        chk("cfg_next", core_ilen, 8'd3);
        req0 = 0;
        core_done = 1; tick(); tick(); core_done = 0; tick();

        // Reset during a ch1 job.
        req1 = 1; ilen1 = 8'd5; empty1 = 0;
        tick();
        req1 = 0;
        chk("r_gnt1", {gnt0, gnt1}, 2'b01);
        tick();
        chk("r_flag", core_empty, 1'b0);
        rst = 1;
        #1;
        chk("r_async", {gnt1, core_empty}, 2'b01);
        chk("r_ilen", core_ilen, 8'd0);
        tick();
        rst = 0; req0 = 1; req1 = 1;
        tick();
        chk("r_next", {gnt0, gnt1}, 2'b10);
        req0 = 0; req1 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
